// File: rtl/prim_sync_reqack_arb.sv
// rtl/prim_sync_reqack_arb.sv - round-robin DST-side arbiter sharing one REQ/ACK data channel
// Optional feature macro: PRIM_SYNC_REQACK_ARB_EMPTY_ACK_EN (ack an idle REQ with an all-zero word).
// Data and client ID are registered on load and held unchanged through the handshake and the
// following HoldCycles cycles, so the SRC side can sample data_o without a data register.
module prim_sync_reqack_arb #(
  parameter int NumClients = 4,
  parameter int Width      = 32,
  parameter int HoldCycles = 4,
  localparam int IdW       = $clog2(NumClients)
) (
  input  logic                        clk_dst_i,
  input  logic                        rst_dst_ni,
  input  logic [NumClients-1:0]       client_valid_i,
  input  logic [NumClients*Width-1:0] client_data_i,
  output logic [NumClients-1:0]       client_ready_o,
  input  logic                        dst_req_i,
  output logic                        dst_ack_o,
  output logic [Width-1:0]            data_o,
  output logic [IdW-1:0]              id_o,
  output logic                        busy_o
);

  localparam int CntW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoaded = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [Width-1:0]      data_q, data_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  gnt_found;
  logic [IdW-1:0]        gnt_idx;
  logic [IdW-1:0]        cand;
  logic [NumClients-1:0] gnt_oh;

  // Round-robin search: first valid client after the last one served, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    gnt_oh    = '0;
    for (int off = 1; off <= NumClients; off++) begin
      cand = IdW'((int'(ptr_q) + off) % NumClients);
      if (!gnt_found && client_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  // Sequencer: load a granted word, ack one REQ, then freeze the outputs for the hold window.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    id_d           = id_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    client_ready_o = '0;
    dst_ack_o      = 1'b0;
    case (state_q)
      StIdle: begin
        client_ready_o = gnt_oh;
        if (gnt_found) begin
          data_d  = client_data_i[int'(gnt_idx)*Width +: Width];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = StLoaded;
        end
`ifdef PRIM_SYNC_REQACK_ARB_EMPTY_ACK_EN
        else if (dst_req_i) begin
          // Nothing to send: answer with a zero word so the SRC side never stalls.
          dst_ack_o = 1'b1;
          data_d    = '0;
          id_d      = '0;
          if (HoldCycles == 0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = CntW'(HoldCycles - 1);
            state_d = StHold;
          end
        end
`endif
      end
      StLoaded: begin
        dst_ack_o = dst_req_i;
        if (dst_req_i) begin
          if (HoldCycles == 0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = CntW'(HoldCycles - 1);
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any loaded word.
  always_ff @(posedge clk_dst_i or negedge rst_dst_ni) begin
    if (!rst_dst_ni) begin
      state_q <= StIdle;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= IdW'(NumClients - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign id_o   = id_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_prim_sync_reqack_arb.sv
// tb/tb_prim_sync_reqack_arb.sv - self-checking bench for prim_sync_reqack_arb (HoldCycles 4 and 0)
module tb_prim_sync_reqack_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: HoldCycles=4, index 1: HoldCycles=0
  logic [N-1:0]   valid [2];
  logic [N*W-1:0] cdata [2];
  logic           req   [2];
  logic [N-1:0]   ready [2];
  logic           ack   [2];
  logic [W-1:0]   dout  [2];
  logic [IW-1:0]  idout [2];
  logic           busy  [2];

  prim_sync_reqack_arb #(.NumClients(N), .Width(W), .HoldCycles(4)) u_dut_h4 (
    .clk_dst_i(clk), .rst_dst_ni(rst_n),
    .client_valid_i(valid[0]), .client_data_i(cdata[0]), .client_ready_o(ready[0]),
    .dst_req_i(req[0]), .dst_ack_o(ack[0]), .data_o(dout[0]), .id_o(idout[0]), .busy_o(busy[0])
  );

  prim_sync_reqack_arb #(.NumClients(N), .Width(W), .HoldCycles(0)) u_dut_h0 (
    .clk_dst_i(clk), .rst_dst_ni(rst_n),
    .client_valid_i(valid[1]), .client_data_i(cdata[1]), .client_ready_o(ready[1]),
    .dst_req_i(req[1]), .dst_ack_o(ack[1]), .data_o(dout[1]), .id_o(idout[1]), .busy_o(busy[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is either pending handshake, or we are counting down a hold window.
  int           hold_cfg [2] = '{4, 0};
  bit           m_word   [2];
  int           m_hold   [2];
  logic [W-1:0] m_data   [2];
  int           m_id     [2];
  int           m_ptr    [2];
  logic         last_ack [2];
  int gnt_q0[$], gnt_q1[$], ack_q0[$], ack_q1[$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit   idle;
      int   g;
      logic [N-1:0] e_ready;
      logic e_ack;
      if (!rst_n) begin
        m_word[k] = 0; m_hold[k] = 0; m_data[k] = '0; m_id[k] = 0; m_ptr[k] = N - 1;
      end
      idle = !m_word[k] && (m_hold[k] == 0);
      g = -1;
      if (idle) begin
        for (int o = 1; o <= N; o++) begin
          int i;
          i = (m_ptr[k] + o) % N;
          if (g < 0 && valid[k][i]) g = i;
        end
      end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_ack = m_word[k] && req[k];
`ifdef PRIM_SYNC_REQACK_ARB_EMPTY_ACK_EN
      if (idle && req[k] && valid[k] == '0) e_ack = 1'b1;
`endif
      chk($sformatf("ready%0d", k), 64'(ready[k]), 64'(e_ready));
      chk($sformatf("ack%0d", k),   64'(ack[k]),   64'(e_ack));
      chk($sformatf("busy%0d", k),  64'(busy[k]),  64'(!idle));
      chk($sformatf("data%0d", k),  64'(dout[k]),  64'(m_data[k]));
      chk($sformatf("id%0d", k),    64'(idout[k]), 64'(m_id[k]));
      last_ack[k] = ack[k];
      if (rst_n) begin
        if (ready[k] != '0) begin
          for (int i = 0; i < N; i++) if (ready[k][i]) begin
            if (k == 0) gnt_q0.push_back(i); else gnt_q1.push_back(i);
          end
        end
        if (ack[k]) begin
          if (k == 0) ack_q0.push_back(cyc); else ack_q1.push_back(cyc);
        end
        if (idle && g >= 0) begin
          m_word[k] = 1; m_data[k] = cdata[k][g*W +: W]; m_id[k] = g; m_ptr[k] = g;
        end else if (m_word[k] && req[k]) begin
          m_word[k] = 0; m_hold[k] = hold_cfg[k];
        end else if (m_hold[k] > 0) begin
          m_hold[k]--;
        end
`ifdef PRIM_SYNC_REQACK_ARB_EMPTY_ACK_EN
        else if (idle && req[k] && valid[k] == '0) begin
          m_data[k] = '0; m_id[k] = 0; m_hold[k] = hold_cfg[k];
        end
`endif
      end
    end
  end

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_q0.delete(); gnt_q1.delete(); ack_q0.delete(); ack_q1.delete();
  endtask

  initial begin
    int start;
    bit busy_seen;
    for (int k = 0; k < 2; k++) begin
      valid[k] = '0; cdata[k] = '0; req[k] = 1'b0;
    end

    // 1: single client 2, REQ already waiting
    repeat (3) step_in();
    rst_n = 1'b1;
    valid[0] = 4'b0100;
    cdata[0][2*W +: W] = 32'hA5A5_0001;
    req[0] = 1'b1;
    @(negedge clk);
    chk("t1_ready", 64'(ready[0]), 64'h4);
    chk("t1_no_ack_idle", 64'(ack[0]), 64'h0);
    step_in();
    valid[0] = '0;
    @(negedge clk);
    chk("t1_ack", 64'(ack[0]), 64'h1);
    chk("t1_data", 64'(dout[0]), 64'hA5A5_0001);
    chk("t1_id", 64'(idout[0]), 64'h2);

    // 3: REQ held high through HOLD is not acked, data frozen
    for (int i = 0; i < 4; i++) begin
      step_in();
      @(negedge clk);
      chk("t3_hold_ack", 64'(ack[0]), 64'h0);
      chk("t3_hold_data", 64'(dout[0]), 64'hA5A5_0001);
      chk("t3_hold_busy", 64'(busy[0]), 64'h1);
    end
    step_in();
    req[0] = 1'b0;
    valid[0] = 4'b0010;
    @(negedge clk);
    chk("t3_idle_busy", 64'(busy[0]), 64'h0);
    chk("t3_next_ready", 64'(ready[0]), 64'h2);
    step_in();
    valid[0] = '0;
    req[0] = 1'b1;
    @(negedge clk);
    chk("t3_next_ack", 64'(ack[0]), 64'h1);
    chk("t3_next_id", 64'(idout[0]), 64'h1);
    step_in();
    req[0] = 1'b0;

    // 2: all clients valid, REQ always high
    rst_n = 1'b0;
    repeat (2) step_in();
    clear_logs();
    rst_n = 1'b1;
    valid[0] = 4'b1111;
    for (int i = 0; i < N; i++) cdata[0][i*W +: W] = 32'h1000 + i;
    req[0] = 1'b1;
    repeat (30) step_in();
    chk("t2_gnt_count", 64'(gnt_q0.size() >= 5), 64'h1);
    if (gnt_q0.size() >= 5) begin
      chk("t2_gnt0", 64'(gnt_q0[0]), 64'd0);
      chk("t2_gnt1", 64'(gnt_q0[1]), 64'd1);
      chk("t2_gnt2", 64'(gnt_q0[2]), 64'd2);
      chk("t2_gnt3", 64'(gnt_q0[3]), 64'd3);
      chk("t2_gnt4", 64'(gnt_q0[4]), 64'd0);
    end
    chk("t2_ack_count", 64'(ack_q0.size() >= 3), 64'h1);
    if (ack_q0.size() >= 3) begin
      chk("t2_spacing_a", 64'(ack_q0[1] - ack_q0[0]), 64'd6);
      chk("t2_spacing_b", 64'(ack_q0[2] - ack_q0[1]), 64'd6);
    end
    valid[0] = '0;
    req[0] = 1'b0;

    // 4: REQ with no client valid
    rst_n = 1'b0;
    step_in();
    rst_n = 1'b1;
    step_in();
    clear_logs();
    req[0] = 1'b1;
    start = cyc;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy[0]) busy_seen = 1'b1;
      step_in();
    end
`ifdef PRIM_SYNC_REQACK_ARB_EMPTY_ACK_EN
    chk("t4_ack_count", 64'(ack_q0.size()), 64'd4);
    if (ack_q0.size() > 0) chk("t4_first_ack", 64'(ack_q0[0]), 64'(start));
    chk("t4_data_zero", 64'(dout[0]), 64'h0);
`else
    chk("t4_ack_count", 64'(ack_q0.size()), 64'd0);
    chk("t4_busy_seen", 64'(busy_seen), 64'h0);
`endif
    req[0] = 1'b0;

    // 5: reset while LOADED
    step_in();
    valid[0] = 4'b0001;
    cdata[0][0 +: W] = 32'h1234;
    step_in();
    valid[0] = '0;
    @(negedge clk);
    chk("t5_loaded_data", 64'(dout[0]), 64'h1234);
    chk("t5_loaded_busy", 64'(busy[0]), 64'h1);
    step_in();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_data", 64'(dout[0]), 64'h0);
    chk("t5_rst_busy", 64'(busy[0]), 64'h0);
    chk("t5_rst_ack", 64'(ack[0]), 64'h0);
    step_in();
    rst_n = 1'b1;
    valid[0] = 4'b1111;
    @(negedge clk);
    chk("t5_restart_gnt", 64'(ready[0]), 64'h1);
    step_in();
    valid[0] = '0;

    // 6: HoldCycles=0 instance, clients 1 and 3
    clear_logs();
    valid[1] = 4'b1010;
    req[1] = 1'b1;
    repeat (8) step_in();
    chk("t6_gnt_count", 64'(gnt_q1.size() >= 3), 64'h1);
    if (gnt_q1.size() >= 3) begin
      chk("t6_gnt0", 64'(gnt_q1[0]), 64'd1);
      chk("t6_gnt1", 64'(gnt_q1[1]), 64'd3);
      chk("t6_gnt2", 64'(gnt_q1[2]), 64'd1);
    end
    chk("t6_ack_count", 64'(ack_q1.size() >= 2), 64'h1);
    if (ack_q1.size() >= 2) chk("t6_spacing", 64'(ack_q1[1] - ack_q1[0]), 64'd2);
    valid[1] = '0;
    req[1] = 1'b0;

    // randomized traffic on both instances, model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      step_in();
      rst_n = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < 2; k++) begin
        if (!(req[k] && !last_ack[k])) req[k] = ($urandom_range(0, 3) != 0);
        valid[k] = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15) | 4'(c[0] ? 4'hf : 4'h0));
        for (int i = 0; i < N; i++) cdata[k][i*W +: W] = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
